// File: rtl/pe_axi_rd_arbiter.sv
// pe_axi_rd_arbiter: round-robin share of one AXI4 read master
// between NUM_REQ PE clients, one burst in flight, sticky R errors.
module pe_axi_rd_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 4,
    localparam int OW            = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_arvalid,
    input  logic [NUM_REQ*AXI_ADDR_WIDTH-1:0] req_araddr,
    input  logic [NUM_REQ*8-1:0]              req_arlen,
    output logic [NUM_REQ-1:0]                req_arready,
    output logic [NUM_REQ-1:0]                req_rvalid,
    output logic [AXI_DATA_WIDTH-1:0]         req_rdata,
    output logic [1:0]                        req_rresp,
    output logic                              req_rlast,
    input  logic [NUM_REQ-1:0]                req_rready,
    output logic [AXI_ID_WIDTH-1:0]           axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0]         axi_araddr,
    output logic [7:0]                        axi_arlen,
    output logic [2:0]                        axi_arsize,
    output logic [1:0]                        axi_arburst,
    output logic [3:0]                        axi_arcache,
    output logic [2:0]                        axi_arprot,
    output logic                              axi_arvalid,
    input  logic                              axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]           axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0]         axi_rdata,
    input  logic [1:0]                        axi_rresp,
    input  logic                              axi_rlast,
    input  logic                              axi_rvalid,
    output logic                              axi_rready,
    output logic                              busy,
    output logic [OW-1:0]                     owner,
    output logic [NUM_REQ-1:0]                err_sticky,
    input  logic                              err_clr
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t        state, state_nxt;
    logic [OW-1:0] rr_ptr;
    logic [OW-1:0] gnt_idx;
    logic          gnt_any;
    logic [7:0]    beat_cnt;
    logic          r_hs;
    logic          r_err;

    assign axi_arsize  = 3'd3;
    assign axi_arburst = 2'b01;
    assign axi_arcache = 4'd3;
    assign axi_arprot  = 3'b000;
    assign req_rdata   = axi_rdata;
    assign req_rresp   = axi_rresp;
    assign req_rlast   = axi_rlast;

    // First requester at or above rr_ptr, wrapping; downward scan keeps the nearest.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_arvalid[(int'(rr_ptr) + i) % NUM_REQ]) begin
                gnt_any = 1'b1;
                gnt_idx = OW'((int'(rr_ptr) + i) % NUM_REQ);
            end
        end
    end

    // Next state plus handshake outputs; R path is a pure pass-through to the owner.
    always_comb begin
        state_nxt   = state;
        req_arready = '0;
        req_rvalid  = '0;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        unique case (state)
            IDLE: begin
                if (gnt_any) begin
                    req_arready[gnt_idx] = 1'b1;
                    state_nxt            = ADDR;
                end
            end
            ADDR: begin
                axi_arvalid = 1'b1;
                if (axi_arready) state_nxt = DATA;
            end
            DATA: begin
                axi_rready        = req_rready[owner];
                req_rvalid[owner] = axi_rvalid;
                if (axi_rvalid && req_rready[owner] && axi_rlast) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy  = (state != IDLE);
    assign r_hs  = (state == DATA) && axi_rvalid && axi_rready;
    assign r_err = (axi_rid != axi_arid) || (axi_rresp != 2'b00) ||
                   (axi_rlast && (beat_cnt != axi_arlen)) ||
                   (!axi_rlast && (beat_cnt == axi_arlen));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Capture the winner's request so AR stays stable through ADDR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            owner      <= '0;
            axi_araddr <= '0;
            axi_arlen  <= '0;
            axi_arid   <= '0;
        end else if (state == IDLE && gnt_any) begin
            rr_ptr     <= OW'((int'(gnt_idx) + 1) % NUM_REQ);
            owner      <= gnt_idx;
            axi_araddr <= req_araddr[int'(gnt_idx)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
            axi_arlen  <= req_arlen[int'(gnt_idx)*8 +: 8];
            axi_arid   <= AXI_ID_WIDTH'(gnt_idx);
        end
    end

    // Beat counter: zeroed on AR accept, bumped per accepted R beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            beat_cnt <= '0;
        else if (state == ADDR && axi_arready) beat_cnt <= '0;
        else if (r_hs)                         beat_cnt <= beat_cnt + 8'd1;
    end

    // Sticky per-client error flags; clear wins over a same-cycle set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             err_sticky        <= '0;
        else if (err_clr)       err_sticky        <= '0;
        else if (r_hs && r_err) err_sticky[owner] <= 1'b1;
    end

endmodule

// File: tb/tb_pe_axi_rd_arbiter.sv
// tb_pe_axi_rd_arbiter: directed bench for pe_axi_rd_arbiter
// with hand-computed expectations and immediate assertions.
module tb_pe_axi_rd_arbiter;

    logic         clk;
    logic         rst_n;
    logic [3:0]   req_arvalid;
    logic [127:0] req_araddr;
    logic [31:0]  req_arlen;
    logic [3:0]   req_arready;
    logic [3:0]   req_rvalid;
    logic [63:0]  req_rdata;
    logic [1:0]   req_rresp;
    logic         req_rlast;
    logic [3:0]   req_rready;
    logic [3:0]   axi_arid;
    logic [31:0]  axi_araddr;
    logic [7:0]   axi_arlen;
    logic [2:0]   axi_arsize;
    logic [1:0]   axi_arburst;
    logic [3:0]   axi_arcache;
    logic [2:0]   axi_arprot;
    logic         axi_arvalid;
    logic         axi_arready;
    logic [3:0]   axi_rid;
    logic [63:0]  axi_rdata;
    logic [1:0]   axi_rresp;
    logic         axi_rlast;
    logic         axi_rvalid;
    logic         axi_rready;
    logic         busy;
    logic [1:0]   owner;
    logic [3:0]   err_sticky;
    logic         err_clr;

    int vectors     = 0;
    int miscompares = 0;

    pe_axi_rd_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req_arvalid(req_arvalid), .req_araddr(req_araddr),
        .req_arlen(req_arlen), .req_arready(req_arready),
        .req_rvalid(req_rvalid), .req_rdata(req_rdata),
        .req_rresp(req_rresp), .req_rlast(req_rlast),
        .req_rready(req_rready),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr),
        .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst), .axi_arcache(axi_arcache),
        .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid),
        .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .busy(busy), .owner(owner),
        .err_sticky(err_sticky), .err_clr(err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    // One len-0 burst for client c with the given R id/resp; clr drives err_clr on the beat.
    task automatic single(input int c, input logic [3:0] rid, input logic [1:0] resp, input logic clr);
        req_araddr[c*32 +: 32] = 32'h5000 + 32'(c);
        req_arlen[c*8 +: 8]    = 8'd0;
        req_arvalid            = 4'(1 << c);
        axi_rvalid             = 1'b0;
        #1 check("single_grant", 64'(req_arready), 64'(1) << c);
        cyc;
        req_arvalid = 4'b0000;
        cyc;
        axi_rvalid = 1'b1;
        axi_rid    = rid;
        axi_rresp  = resp;
        axi_rlast  = 1'b1;
        err_clr    = clr;
        #1 check("single_rvalid", 64'(req_rvalid), 64'(1) << c);
        cyc;
        axi_rvalid = 1'b0;
        axi_rresp  = 2'b00;
        axi_rlast  = 1'b0;
        err_clr    = 1'b0;
        #1 check("single_idle", 64'(busy), 64'h0);
    endtask

    initial begin
        int h;
        rst_n       = 1'b0;
        req_arvalid = '0;
        req_araddr  = '0;
        req_arlen   = '0;
        req_rready  = '0;
        axi_arready = 1'b0;
        axi_rid     = '0;
        axi_rdata   = '0;
        axi_rresp   = '0;
        axi_rlast   = 1'b0;
        axi_rvalid  = 1'b0;
        err_clr     = 1'b0;

        repeat (2) cyc;
        #1;
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_arvalid", 64'(axi_arvalid), 64'h0);
        check("rst_araddr", 64'(axi_araddr), 64'h0);
        check("rst_owner", 64'(owner), 64'h0);
        check("rst_err", 64'(err_sticky), 64'h0);
        check("rst_arready", 64'(req_arready), 64'h0);
        check("rst_const", {52'h0, axi_arsize, axi_arburst, axi_arcache, axi_arprot},
              {52'h0, 3'd3, 2'b01, 4'd3, 3'b000});
        rst_n = 1'b1;
        cyc;

        // single client 2, len 7
        req_araddr[2*32 +: 32] = 32'h1000;
        req_arlen[2*8 +: 8]    = 8'd7;
        req_arvalid = 4'b0100;
        req_rready  = 4'b1111;
        axi_arready = 1'b1;
        axi_rvalid  = 1'b1;
        axi_rid     = 4'd2;
        #1 check("t1_grant", 64'(req_arready), 64'h4);
        cyc;
        req_arvalid = 4'b0000;
        #1;
        check("t1_arvalid", 64'(axi_arvalid), 64'h1);
        check("t1_arid", 64'(axi_arid), 64'h2);
        check("t1_araddr", 64'(axi_araddr), 64'h1000);
        check("t1_arlen", 64'(axi_arlen), 64'h7);
        check("t1_owner", 64'(owner), 64'h2);
        check("t1_addr_rvalid", 64'(req_rvalid), 64'h0);
        cyc;
        for (int b = 0; b < 8; b++) begin
            axi_rdata = 64'hD0 + 64'(b);
            axi_rlast = (b == 7);
            #1;
            check("t1_rvalid", 64'(req_rvalid), 64'h4);
            check("t1_rdata", req_rdata, 64'hD0 + 64'(b));
            cyc;
        end
        #1;
        check("t1_busy", 64'(busy), 64'h0);
        check("t1_err", 64'(err_sticky), 64'h0);
        check("t1_idle_rvalid", 64'(req_rvalid), 64'h0);
        check("t1_idle_rready", 64'(axi_rready), 64'h0);
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;

        // reset pulse so contention starts with rr_ptr at 0
        rst_n = 1'b0;
        cyc;
        rst_n = 1'b1;
        cyc;

        // contention: all request, len 0
        for (int k = 0; k < 4; k++) begin
            req_araddr[k*32 +: 32] = 32'(256 * (k + 1));
            req_arlen[k*8 +: 8]    = 8'd0;
        end
        req_arvalid = 4'b1111;
        axi_rvalid  = 1'b1;
        axi_rlast   = 1'b1;
        for (int k = 0; k < 5; k++) begin
            axi_rid = 4'(k % 4);
            #1 check("t2_grant", 64'(req_arready), 64'(1) << (k % 4));
            cyc;
            #1;
            check("t2_owner", 64'(owner), 64'(k % 4));
            check("t2_araddr", 64'(axi_araddr), 64'(256 * ((k % 4) + 1)));
            cyc;
            #1 check("t2_rvalid", 64'(req_rvalid), 64'(1) << (k % 4));
            cyc;
        end
        req_arvalid = 4'b0000;
        axi_rvalid  = 1'b0;
        axi_rlast   = 1'b0;
        #1 check("t2_err", 64'(err_sticky), 64'h0);

        // backpressure: client 1, len 3, rready toggling
        req_araddr[1*32 +: 32] = 32'h2000;
        req_arlen[1*8 +: 8]    = 8'd3;
        req_arvalid = 4'b0010;
        req_rready  = 4'b0000;
        axi_rid     = 4'd1;
        #1 check("t3_grant", 64'(req_arready), 64'h2);
        cyc;
        req_arvalid = 4'b0000;
        cyc;
        axi_rvalid = 1'b1;
        h = 0;
        for (int c = 0; c < 7; c++) begin
            req_rready = (c % 2 == 0) ? 4'b0010 : 4'b0000;
            axi_rdata  = 64'hA0 + 64'(h);
            axi_rlast  = (h == 3);
            #1;
            check("t3_rready", 64'(axi_rready), (c % 2 == 0) ? 64'h1 : 64'h0);
            check("t3_rvalid", 64'(req_rvalid), 64'h2);
            check("t3_rdata", req_rdata, 64'hA0 + 64'(h));
            check("t3_busy", 64'(busy), 64'h1);
            if (c % 2 == 0) h++;
            cyc;
        end
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        req_rready = 4'b1111;
        #1;
        check("t3_done", 64'(busy), 64'h0);
        check("t3_err", 64'(err_sticky), 64'h0);

        // AR stall: client 3 wins, client 0 waits
        req_araddr[3*32 +: 32] = 32'h3000;
        req_arlen[3*8 +: 8]    = 8'd0;
        req_araddr[0*32 +: 32] = 32'h4000;
        req_arlen[0*8 +: 8]    = 8'd3;
        req_arvalid = 4'b1001;
        axi_arready = 1'b0;
        #1 check("t4_grant", 64'(req_arready), 64'h8);
        cyc;
        req_arvalid = 4'b0001;
        repeat (5) begin
            #1;
            check("t4_arvalid", 64'(axi_arvalid), 64'h1);
            check("t4_araddr", 64'(axi_araddr), 64'h3000);
            check("t4_arlen", 64'(axi_arlen), 64'h0);
            check("t4_arid", 64'(axi_arid), 64'h3);
            check("t4_nogrant", 64'(req_arready), 64'h0);
            cyc;
        end
        axi_arready = 1'b1;
        cyc;
        axi_rvalid = 1'b1;
        axi_rid    = 4'd3;
        axi_rlast  = 1'b1;
        #1 check("t4_rvalid", 64'(req_rvalid), 64'h8);
        cyc;

        // early rlast on client 0 (len 3, rlast at beat 2)
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        axi_rid    = 4'd0;
        #1 check("t5_grant", 64'(req_arready), 64'h1);
        cyc;
        req_arvalid = 4'b0000;
        #1 check("t5_arlen", 64'(axi_arlen), 64'h3);
        cyc;
        axi_rvalid = 1'b1;
        cyc;
        cyc;
        axi_rlast = 1'b1;
        cyc;
        axi_rvalid = 1'b0;
        axi_rlast  = 1'b0;
        #1;
        check("t5_idle", 64'(busy), 64'h0);
        check("t5_err_rlast", 64'(err_sticky), 64'h1);

        single(1, 4'd1, 2'b10, 1'b0);
        check("t5_err_rresp", 64'(err_sticky), 64'h3);
        single(2, 4'd0, 2'b00, 1'b0);
        check("t5_err_rid", 64'(err_sticky), 64'h7);
        err_clr = 1'b1;
        cyc;
        err_clr = 1'b0;
        #1 check("t5_err_clr", 64'(err_sticky), 64'h0);
        single(3, 4'd3, 2'b10, 1'b1);
        check("t5_clr_prio", 64'(err_sticky), 64'h0);

        // reset mid-burst: client 2, len 7, reset after 3 beats
        req_araddr[2*32 +: 32] = 32'h7000;
        req_arlen[2*8 +: 8]    = 8'd7;
        req_arvalid = 4'b0100;
        axi_rid     = 4'd2;
        #1 check("t6_grant", 64'(req_arready), 64'h4);
        cyc;
        req_arvalid = 4'b0000;
        cyc;
        axi_rvalid = 1'b1;
        repeat (3) cyc;
        check("t6_midburst", 64'(req_rvalid), 64'h4);
        rst_n = 1'b0;
        #1;
        check("t6_busy", 64'(busy), 64'h0);
        check("t6_rvalid", 64'(req_rvalid), 64'h0);
        check("t6_rready", 64'(axi_rready), 64'h0);
        check("t6_arvalid", 64'(axi_arvalid), 64'h0);
        check("t6_owner", 64'(owner), 64'h0);
        check("t6_ar", {24'h0, axi_arid, axi_arlen, axi_araddr}, 64'h0);
        axi_rvalid = 1'b0;
        cyc;
        rst_n = 1'b1;
        cyc;
        req_araddr[1*32 +: 32] = 32'h8000;
        req_arlen[1*8 +: 8]    = 8'd0;
        req_araddr[3*32 +: 32] = 32'h9000;
        req_arlen[3*8 +: 8]    = 8'd0;
        req_arvalid = 4'b1010;
        #1 check("t6_regrant", 64'(req_arready), 64'h2);
        cyc;
        req_arvalid = 4'b0000;
        #1;
        check("t6_new_owner", 64'(owner), 64'h1);
        check("t6_new_arid", 64'(axi_arid), 64'h1);
        check("t6_new_araddr", 64'(axi_araddr), 64'h8000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pe_axi_rd_arbiter.md
# pe_axi_rd_arbiter

Round-robin arbiter that shares one AXI4 read master (AR and R channels) between `NUM_REQ` PE read clients. It sits between the PE cores and the memory fabric and serialises their bursts. Exactly one burst is outstanding at a time. R beats are steered back only to the client that owns the burst. It also checks returned beats for protocol errors and keeps per-client sticky error flags.

## Interface
Parameters:
- `NUM_REQ`, 4: number of read clients (2..16).
- `AXI_ADDR_WIDTH`, 32: address width.
- `AXI_DATA_WIDTH`, 64: read data width.
- `AXI_ID_WIDTH`, 4: ID width; must be ≥ clog2(`NUM_REQ`).

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_arvalid`  in  NUM_REQ  per-client read request.
- `req_araddr`  in  NUM_REQ*AXI_ADDR_WIDTH  packed; client k at slice [k*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH].
- `req_arlen`  in  NUM_REQ*8  packed AXI len (beats−1) per client.
- `req_arready`  out  NUM_REQ  one-hot grant/accept pulse.
- `req_rvalid`  out  NUM_REQ  one-hot; a beat is available for the owner.
- `req_rdata`  out  AXI_DATA_WIDTH  broadcast copy of `axi_rdata`.
- `req_rresp`  out  2  broadcast copy of `axi_rresp`.
- `req_rlast`  out  1  broadcast copy of `axi_rlast`.
- `req_rready`  in  NUM_REQ  per-client beat acceptance.
- `axi_arid`  out  AXI_ID_WIDTH  owner index, zero-extended.
- `axi_araddr`  out  AXI_ADDR_WIDTH  registered address.
- `axi_arlen`  out  8  registered len.
- `axi_arsize`  out  3  constant 3'd3.
- `axi_arburst`  out  2  constant 2'b01 (INCR).
- `axi_arcache`  out  4  constant 4'd3.
- `axi_arprot`  out  3  constant 3'b000.
- `axi_arvalid`  out  1  address valid.
- `axi_arready`  in  1  address accepted.
- `axi_rid`  in  AXI_ID_WIDTH  read ID.
- `axi_rdata`  in  AXI_DATA_WIDTH  read data.
- `axi_rresp`  in  2  read response.
- `axi_rlast`  in  1  last beat of burst.
- `axi_rvalid`  in  1  beat valid.
- `axi_rready`  out  1  beat accepted.
- `busy`  out  1  state ≠ IDLE.
- `owner`  out  clog2(NUM_REQ)  current or last granted client.
- `err_sticky`  out  NUM_REQ  per-client error flags.
- `err_clr`  in  1  synchronous clear of all `err_sticky` bits.

## Operation
- FSM states: IDLE, ADDR, DATA.
- **IDLE:**
  - If any `req_arvalid` is high, grant the first set bit searching upward from `rr_ptr` with wrap-around.
  - Same cycle: `req_arready[g]` = 1 (combinational), latch that client's address/len into `axi_araddr`/`axi_arlen`, set `owner`=g, `rr_ptr`=(g+1) mod NUM_REQ.
  - Next state is ADDR.
  - A client must hold its request stable until its `req_arready` pulse.
- **ADDR:**
  - `axi_arvalid`=1; address/len/id stay stable.
  - On `axi_arready`=1: clear beat counter, go to DATA.
- **DATA:**
  - `axi_rready` = `req_rready[owner]`.
  - `req_rvalid[owner]` = `axi_rvalid`; all other `req_rvalid` bits are 0.
  - Each handshake increments the 8-bit beat counter.
  - On handshake with `axi_rlast`=1, go to IDLE.
- **Error checks** (evaluated on every DATA handshake); on violation set `err_sticky[owner]`:
  - `axi_rid` ≠ owner;
  - `axi_rresp` ≠ 2'b00;
  - `axi_rlast`=1 with beat counter ≠ `axi_arlen`;
  - beat counter = `axi_arlen` with `axi_rlast`=0.
  - The burst still ends only on `axi_rlast`.
- **Outside DATA:** `axi_rready`=0 and all `req_rvalid`=0. Beats presented outside DATA are ignored and do not flag errors.
- **Error clear:** `err_clr` has priority over a same-cycle set.
- **Reset** (async, any state, including mid-burst):
  - state=IDLE, `rr_ptr`=0, `owner`=0, beat counter 0, `axi_araddr`/`axi_arlen`/`axi_arid`=0, `err_sticky`=0.
  - All valid/ready outputs are 0 and `busy`=0.
  - An abandoned burst is not recovered; the fabric must be reset together with this block.

## Timing
- Grant to `axi_arvalid`: 1 cycle (the grant pulse is cycle 0; `axi_arvalid` rises in cycle 1).
- `axi_arvalid` holds until `axi_arready`. With `axi_arready` tied high, ADDR lasts exactly 1 cycle.
- R path is combinational pass-through (zero added latency). Backpressure from `req_rready[owner]` maps directly onto `axi_rready`.
- After the `rlast` handshake, IDLE lasts at least 1 cycle; the next grant occurs in that IDLE cycle.
- Minimum burst-to-burst gap: 2 cycles after `rlast` before the next `axi_arvalid` (IDLE plus grant register).
- Exactly one burst is outstanding; no new AR is issued before `rlast`.

## Test plan
- **Single client:** client 2 requests addr 0x1000, len 7, with `arready` and `rvalid` held high.
  - `arready` pulses once; `axi_arid`=2, `axi_araddr`=0x1000.
  - 8 beats reach only `req_rvalid[2]`; `busy` drops after beat 8; `err_sticky`=0.
- **Contention:** all 4 clients request continuously, len 0 each.
  - Grant order is 0,1,2,3,0.
  - `rr_ptr` wraps and no client is granted twice in a row.
- **Backpressure:** `req_rready[owner]` toggles 1,0,1,0 during a len-3 burst.
  - `axi_rready` mirrors it; beat counter reaches 3 only on the 4th handshake; no data lost.
- **AR stall:** `axi_arready` held low for 5 cycles.
  - `axi_arvalid` stays 1 with stable address, len and id.
  - No other client is granted in that window.
- **Protocol errors:**
  - `rlast` on beat 2 of a len-3 burst → `err_sticky[owner]`=1 and FSM returns to IDLE.
  - `rresp`=2'b10 on another client's burst sets that client's bit.
  - `err_clr` then clears all bits.
- **Reset mid-burst:** assert `rst_n`=0 after beat 3 of 8.
  - All outputs return to reset values immediately (async).
  - After release, a new request from client 1 is granted with `rr_ptr` starting at 0.
